// File: rtl/led_bcd_feeder_pkg.sv
// Shared definitions for the LED BCD feeder.
// Holds the conversion sizes, the FSM state encoding, the LED register
// addresses and the status-word bit positions. It also provides small helper
// functions used by the feeder datapath.
package led_bcd_feeder_pkg;

  localparam int DIGITS      = 10;          // BCD digits held by the accumulator
  localparam int ITER        = 32;          // one shift per binary bit
  localparam int DISP_DIGITS = 8;           // digits the LED driver can show
  localparam int BCD_W       = DIGITS * 4;  // accumulator width
  localparam int BIN_W       = 32;          // binary operand width
  localparam int CNT_W       = 5;           // iteration counter width

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  localparam logic ADDR_DIGIT  = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_NEG_BIT = 0;
  localparam int STAT_OVF_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_WR_DIG  = 2'd2,
    ST_WR_STAT = 2'd3
  } state_t;

  // Any digit above the displayable range means the value does not fit.
  function automatic logic bcd_overflow(input logic [BCD_W-1:0] bcd);
    return |bcd[BCD_W-1:DISP_DIGITS*4];
  endfunction

  // Builds the status word from the overflow and sign flags.
  function automatic logic [31:0] status_word(input logic ovf, input logic neg);
    logic [31:0] w;
    w               = 32'h0000_0000;
    w[STAT_OVF_BIT] = ovf;
    w[STAT_NEG_BIT] = neg;
    return w;
  endfunction

endpackage

// File: rtl/led_bcd_feeder_bcd_adjust_shift.sv
// One double-dabble step.
// Adds 3 to every BCD nibble that is 5 or more, then shifts the combined
// {bcd, bin} vector left by one bit. The step is purely combinational.
// Ports:
//   bcd_in  [39:0] : current BCD accumulator (10 digits)
//   bin_in  [31:0] : remaining binary bits, MSB shifts out next
//   bcd_out [39:0] : accumulator after adjust and shift
//   bin_out [31:0] : binary bits after the shift
module bcd_adjust_shift
  import led_bcd_feeder_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic [BIN_W-1:0] bin_out
);

  logic [BCD_W-1:0] adj_s;
  logic             unused_msb_s;

  // Per-digit add-3 correction so the following shift carries correctly in BCD.
  always_comb begin
    adj_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[d*4 +: 4] >= 4'd5) begin
        adj_s[d*4 +: 4] = bcd_in[d*4 +: 4] + 4'd3;
      end else begin
        adj_s[d*4 +: 4] = bcd_in[d*4 +: 4];
      end
    end
  end

  // The top accumulator bit never carries anything useful: 2^32-1 has a
  // leading digit of 4, so nothing is lost when it shifts out.
  assign unused_msb_s       = adj_s[BCD_W-1];
  assign {bcd_out, bin_out} = {adj_s[BCD_W-2:0], bin_in, 1'b0};

endmodule

// File: rtl/led_bcd_feeder.sv
// LED BCD feeder.
// Converts a 32-bit binary value to packed BCD with a sequential double-dabble
// (one bit per cycle, 32 cycles). It then writes two words into the LED
// driver register file on back-to-back cycles:
//   - the digit word (address 0);
//   - the status word (address 1), which holds overflow in bit 1 and sign in
//     bit 0.
// Build option:
//   LED_BCD_SIGNED_EN treats Value as two's complement and reports the sign.
//   Without it, Value is unsigned and the sign bit is always 0.
// Ports:
//   Clock        : system clock, rising edge
//   Reset        : synchronous active-high reset
//   Start        : one-cycle convert request, honoured only when idle
//   Value [31:0] : operand, sampled on the edge that accepts Start
//   Busy         : high from the accepting edge until the second write ends
//   Done         : one-cycle pulse together with the status write
//   LED_WB       : LED driver write strobe
//   LED_Addr     : LED driver word address (0 digits, 1 status)
//   LED_WD[31:0] : LED driver write data
module led_bcd_feeder
  import led_bcd_feeder_pkg::*;
#(
  parameter logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Value,
  output logic        Busy,
  output logic        Done,
  output logic        LED_WB,
  output logic        LED_Addr,
  output logic [31:0] LED_WD
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_r;

  logic [BIN_W-1:0] mag_s;
  logic             neg_in_s;
  logic [BCD_W-1:0] bcd_step_s;
  logic [BIN_W-1:0] bin_step_s;
  logic             ovf_s;

  // Operand magnitude and sign. In signed builds, 0x8000_0000 negates to
  // itself, which reads correctly as 2_147_483_648 when treated as unsigned.
`ifdef LED_BCD_SIGNED_EN
  always_comb begin
    if (Value[31]) begin
      mag_s = ~Value + 32'd1;
    end else begin
      mag_s = Value;
    end
    neg_in_s = Value[31];
  end
`else
  always_comb begin
    mag_s    = Value;
    neg_in_s = 1'b0;
  end
`endif

  bcd_adjust_shift u_step (
    .bcd_in  (bcd_r),
    .bin_in  (bin_r),
    .bcd_out (bcd_step_s),
    .bin_out (bin_step_s)
  );

  assign ovf_s = bcd_overflow(bcd_r);

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Start is only looked at in IDLE, so requests made while
  // busy are dropped rather than queued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_nxt_s = ST_CONV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (cnt_r == LAST_ITER) begin
          state_nxt_s = ST_WR_DIG;
        end else begin
          state_nxt_s = ST_CONV;
        end
      end
      ST_WR_DIG:  state_nxt_s = ST_WR_STAT;
      ST_WR_STAT: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Conversion datapath: load on accept, then one double-dabble step per CONV cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bin_r <= '0;
      bcd_r <= '0;
      cnt_r <= '0;
      neg_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            bin_r <= mag_s;
            bcd_r <= '0;
            cnt_r <= '0;
            neg_r <= neg_in_s;
          end
        end
        ST_CONV: begin
          bin_r <= bin_step_s;
          bcd_r <= bcd_step_s;
          cnt_r <= cnt_r + 5'd1;
        end
        default: begin
          bin_r <= bin_r;
          bcd_r <= bcd_r;
          cnt_r <= cnt_r;
          neg_r <= neg_r;
        end
      endcase
    end
  end

  // Output decode from registered state only; nothing reaches the outputs
  // combinationally from Start or Value.
  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    LED_WB   = 1'b0;
    LED_Addr = ADDR_DIGIT;
    LED_WD   = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        Busy = 1'b0;
      end
      ST_CONV: begin
        Busy = 1'b1;
      end
      ST_WR_DIG: begin
        Busy     = 1'b1;
        LED_WB   = 1'b1;
        LED_Addr = ADDR_DIGIT;
        if (ovf_s) begin
          LED_WD = OVF_PATTERN;
        end else begin
          LED_WD = bcd_r[DISP_DIGITS*4-1:0];
        end
      end
      ST_WR_STAT: begin
        Busy     = 1'b1;
        Done     = 1'b1;
        LED_WB   = 1'b1;
        LED_Addr = ADDR_STATUS;
        LED_WD   = status_word(ovf_s, neg_r);
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule
